// File: rtl/fifo_arbiter_rr_pkg.sv
// Shared definitions for the FIFO arbiter slice: controller state encoding and
// default sizing used by both the arbiter and the controller FSM.
package fifo_arbiter_rr_pkg;

    typedef enum logic [3:0] {
        StReset  = 4'b0001,
        StInit   = 4'b0010,
        StIdle   = 4'b0100,
        StActive = 4'b1000
    } ctrl_state_e;

    localparam int unsigned NumFifosDefault = 4;
    localparam int unsigned DataWDefault    = 6;

    // A single FIFO still needs a 1-bit pointer so the vectors stay legal.
    function automatic int unsigned ptr_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational round-robin picker: grants the first requester found when
// scanning from ptr upwards, wrapping modulo NUM_FIFOS.
module rr_priority_sel
    import fifo_arbiter_rr_pkg::*;
#(
    parameter int unsigned NUM_FIFOS = NumFifosDefault,
    parameter int unsigned PTR_W     = ptr_width(NUM_FIFOS)
) (
    input  logic [NUM_FIFOS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_FIFOS-1:0] grant,
    output logic [PTR_W-1:0]     index
);

    logic             found;
    logic [PTR_W-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
            cand = PTR_W'((32'(ptr) + k) % NUM_FIFOS);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_arbiter_rr.sv
// Round-robin drain of NUM_FIFOS input FIFOs into one output FIFO, with an
// occupancy hysteresis pause and a running transfer count.
module fifo_arbiter_rr
    import fifo_arbiter_rr_pkg::*;
#(
    parameter int unsigned NUM_FIFOS = NumFifosDefault,
    parameter int unsigned DATA_W    = DataWDefault
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [3:0]                  state,
    input  logic [2:0]                  umbral_superior,
    input  logic [2:0]                  umbral_inferior,
    input  logic [NUM_FIFOS-1:0]        in_empty,
    input  logic [NUM_FIFOS*DATA_W-1:0] in_data,
    input  logic [3:0]                  out_count,
    output logic [NUM_FIFOS-1:0]        pop,
    output logic                        push,
    output logic [DATA_W-1:0]           data_out,
    output logic                        paused,
    output logic [7:0]                  xfer_count
);

    localparam int unsigned     PtrW    = ptr_width(NUM_FIFOS);
    localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_FIFOS - 1);

    logic [NUM_FIFOS-1:0] req;
    logic [NUM_FIFOS-1:0] grant;
    logic [PtrW-1:0]      grant_idx;
    logic [PtrW-1:0]      ptr_q, ptr_d;
    logic [PtrW-1:0]      sel_q, sel_d;
    logic                 push_q, push_d;
    logic                 paused_q, paused_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [7:0]           xfer_q, xfer_d;
    logic [4:0]           occ;
    logic                 active;
    logic                 set_pause;
    logic                 clr_pause;

    assign req = ~in_empty;

    rr_priority_sel #(
        .NUM_FIFOS (NUM_FIFOS),
        .PTR_W     (PtrW)
    ) u_sel (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant),
        .index (grant_idx)
    );

    // Outputs are gated by reset so the synchronous reset wins within its own cycle.
    always_comb begin
        active    = !reset && (state == StActive) && !paused_q;
        pop       = active ? grant : '0;
        push      = push_q && !reset;
        data_out  = data_q;
        if (reset) begin
            data_out = '0;
        end else if (push) begin
            data_out = in_data[32'(sel_q) * DATA_W +: DATA_W];
        end
        occ       = 5'(out_count) + 5'(push);
        set_pause = occ >= 5'(umbral_superior);
        clr_pause = occ <= 5'(umbral_inferior);
        paused     = paused_q;
        xfer_count = xfer_q;
    end

    always_comb begin
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        push_d   = |pop;
        paused_d = paused_q;
        data_d   = data_out;
        xfer_d   = xfer_q;
        if (|pop) begin
            ptr_d = (grant_idx == LastIdx) ? '0 : grant_idx + PtrW'(1);
            sel_d = grant_idx;
        end
        // Hysteresis is frozen outside ACTIVE; set beats clear.
        if (state == StActive) begin
            if (set_pause) begin
                paused_d = 1'b1;
            end else if (clr_pause) begin
                paused_d = 1'b0;
            end
        end
        if (push) begin
            xfer_d = xfer_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= '0;
            sel_q    <= '0;
            push_q   <= 1'b0;
            paused_q <= 1'b0;
            data_q   <= '0;
            xfer_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            push_q   <= push_d;
            paused_q <= paused_d;
            data_q   <= data_d;
            xfer_q   <= xfer_d;
        end
    end

endmodule

// File: tb/tb_fifo_arbiter_rr.sv
// Self-checking bench for fifo_arbiter_rr: behavioural model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_fifo_arbiter_rr;

    localparam int N  = 4;
    localparam int DW = 6;

    localparam logic [3:0] S_RESET  = 4'b0001;
    localparam logic [3:0] S_INIT   = 4'b0010;
    localparam logic [3:0] S_IDLE   = 4'b0100;
    localparam logic [3:0] S_ACTIVE = 4'b1000;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    state;
    logic [2:0]    us, ui;
    logic [N-1:0]  in_empty;
    logic [N*DW-1:0] in_data;
    logic [3:0]    out_count;
    logic [N-1:0]  pop;
    logic          push;
    logic [DW-1:0] data_out;
    logic          paused;
    logic [7:0]    xfer_count;

    always #5 clk = ~clk;

    fifo_arbiter_rr #(
        .NUM_FIFOS (N),
        .DATA_W    (DW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .state           (state),
        .umbral_superior (us),
        .umbral_inferior (ui),
        .in_empty        (in_empty),
        .in_data         (in_data),
        .out_count       (out_count),
        .pop             (pop),
        .push            (push),
        .data_out        (data_out),
        .paused          (paused),
        .xfer_count      (xfer_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            m_ptr;
    bit            m_paused;
    bit            m_pend;
    int            m_pidx;
    logic [DW-1:0] m_hold;
    int            m_xfer;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] slice(input int i);
        return in_data[i*DW +: DW];
    endfunction

    function automatic int model_grant();
        if (reset || state != S_ACTIVE || m_paused) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (!in_empty[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_clear();
        m_ptr = 0; m_paused = 0; m_pend = 0; m_pidx = 0; m_hold = '0; m_xfer = 0;
    endtask

    // Called mid-cycle with inputs settled: compare, clock, advance the model.
    task automatic clk_step();
        int            g;
        int            occ;
        logic [N-1:0]  e_pop;
        bit            e_push;
        logic [DW-1:0] e_data;
        g      = model_grant();
        e_pop  = (g >= 0) ? (N'(1) << g) : '0;
        e_push = m_pend && !reset;
        e_data = reset ? '0 : (e_push ? slice(m_pidx) : m_hold);
        chk("pop", 32'(pop), 32'(e_pop));
        chk("push", 32'(push), 32'(e_push));
        chk("data_out", 32'(data_out), 32'(e_data));
        chk("paused", 32'(paused), 32'(m_paused));
        chk("xfer_count", 32'(xfer_count), 32'(m_xfer));
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            if (e_push) m_xfer = (m_xfer + 1) % 256;
            m_hold = e_data;
            if (state == S_ACTIVE) begin
                occ = int'(out_count) + int'(e_push);
                if (occ >= int'(us)) m_paused = 1;
                else if (occ <= int'(ui)) m_paused = 0;
            end
            m_pend = (g >= 0);
            if (g >= 0) begin
                m_pidx = g;
                m_ptr  = (g + 1) % N;
            end
        end
        #1;
    endtask

    task automatic set_data();
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = DW'(i * 9 + 5);
    endtask

    initial begin
        reset = 1'b1; state = S_RESET; us = 3'd7; ui = 3'd2;
        in_empty = '1; out_count = 4'd0; set_data();
        @(posedge clk); #1;
        model_clear();

        // Reset held, then first idle cycle
        #3; clk_step();
        reset = 1'b0; state = S_IDLE;
        #3;
        chk("rst_pop", 32'(pop), 32'd0);
        chk("rst_push", 32'(push), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_paused", 32'(paused), 32'd0);
        chk("rst_xfer", 32'(xfer_count), 32'd0);
        clk_step();

        // All FIFOs ready: strict rotation, push one cycle behind
        state = S_ACTIVE; in_empty = '0;
        for (int k = 0; k < 5; k++) begin
            #3;
            chk("rot_pop", 32'(pop), 32'(1) << (k % 4));
            chk("rot_push", 32'(push), 32'(k > 0));
            if (k > 0) chk("rot_data", 32'(data_out), 32'(((k - 1) % 4) * 9 + 5));
            clk_step();
        end
        state = S_IDLE;
        #3;
        chk("rot_tail_push", 32'(push), 32'd1);
        chk("rot_tail_data", 32'(data_out), 32'd5);
        chk("rot_tail_pop", 32'(pop), 32'd0);
        clk_step();

        // Only FIFO 2 ready, pointer moved to 3 first
        state = S_ACTIVE; in_empty = 4'b1011;
        #3; chk("one_pop_a", 32'(pop), 32'b0100); clk_step();
        #3; chk("one_pop_b", 32'(pop), 32'b0100); clk_step();
        state = S_IDLE;
        #3;
        chk("one_push", 32'(push), 32'd1);
        chk("one_data", 32'(data_out), 32'd23);
        clk_step();
        state = S_ACTIVE; in_empty = '0;
        #3; chk("one_ptr3", 32'(pop), 32'b1000); clk_step();
        state = S_IDLE;
        #3; clk_step();

        // Hysteresis 4/2
        us = 3'd4; ui = 3'd2; state = S_ACTIVE; out_count = 4'd4;
        #3; chk("hys_c0_paused", 32'(paused), 32'd0); clk_step();
        out_count = 4'd3;
        #3; chk("hys_c1_paused", 32'(paused), 32'd1); chk("hys_c1_pop", 32'(pop), 32'd0); clk_step();
        #3; chk("hys_c2_paused", 32'(paused), 32'd1); clk_step();
        out_count = 4'd2;
        #3; chk("hys_c3_paused", 32'(paused), 32'd1); clk_step();
        #3; chk("hys_c4_paused", 32'(paused), 32'd0); chk("hys_c4_pop", 32'(pop), 32'b0010); clk_step();
        state = S_IDLE; out_count = 4'd0; us = 3'd7;
        #3; clk_step();

        // Leave ACTIVE with a pop in flight
        state = S_ACTIVE;
        #3; clk_step();
        state = S_IDLE;
        #3; chk("idle_push", 32'(push), 32'd1); chk("idle_pop_a", 32'(pop), 32'd0); clk_step();
        #3; chk("idle_push_end", 32'(push), 32'd0); chk("idle_pop_b", 32'(pop), 32'd0); clk_step();

        // Reset the cycle after a pop
        state = S_ACTIVE;
        #3; clk_step();
        reset = 1'b1;
        #3; chk("mid_rst_push", 32'(push), 32'd0); clk_step();
        reset = 1'b0;
        #3;
        chk("post_rst_xfer", 32'(xfer_count), 32'd0);
        chk("post_rst_push", 32'(push), 32'd0);
        chk("post_rst_pop", 32'(pop), 32'b0001);
        clk_step();
        state = S_IDLE;
        #3; clk_step();

        // Upper threshold of zero pins the pause
        us = 3'd0; ui = 3'd0; state = S_ACTIVE;
        #3; clk_step();
        for (int k = 0; k < 4; k++) begin
            #3; chk("zero_paused", 32'(paused), 32'd1); chk("zero_pop", 32'(pop), 32'd0); clk_step();
        end
        reset = 1'b1;
        #3; clk_step();
        reset = 1'b0; us = 3'd7; ui = 3'd2;

        // 256 transfers wrap the counter
        for (int k = 0; k < 256; k++) begin
            #3; clk_step();
        end
        state = S_IDLE;
        #3; chk("wrap_255", 32'(xfer_count), 32'd255); clk_step();
        #3; chk("wrap_0", 32'(xfer_count), 32'd0); clk_step();

        // Random traffic
        for (int k = 0; k < 800; k++) begin
            int r;
            reset = ($urandom_range(0, 49) == 0);
            r = $urandom_range(0, 9);
            if (r < 7) state = S_ACTIVE;
            else if (r == 7) state = S_IDLE;
            else if (r == 8) state = S_INIT;
            else state = S_RESET;
            us        = 3'($urandom_range(1, 7));
            ui        = 3'($urandom_range(0, int'(us)));
            in_empty  = N'($urandom);
            in_data   = (N*DW)'($urandom);
            out_count = 4'($urandom_range(0, 8));
            #3; clk_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_arbiter_rr.md
FIFO_ARBITER_RR -- requirements
Module: fifo_arbiter_rr

Interface
REQ-001 The block SHALL have parameter NUM_FIFOS, default 4, the number of input FIFOs arbitrated.
REQ-002 The block SHALL have parameter DATA_W, default 6, the data width of each FIFO word.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 state  input  4  one-hot controller state (RESET=0001, INIT=0010, IDLE=0100, ACTIVE=1000).
REQ-006 umbral_superior  input  3  output-FIFO occupancy at which transfers pause.
REQ-007 umbral_inferior  input  3  output-FIFO occupancy at which transfers resume.
REQ-008 in_empty  input  NUM_FIFOS  per-FIFO empty flag.
REQ-009 in_data  input  NUM_FIFOS*DATA_W  packed read data; FIFO i occupies bits [i*DATA_W +: DATA_W], valid one cycle after its pop.
REQ-010 out_count  input  4  current occupancy of the 8-deep output FIFO.
REQ-011 pop  output  NUM_FIFOS  one-hot read strobe to the input FIFOs.
REQ-012 push  output  1  write strobe to the output FIFO.
REQ-013 data_out  output  DATA_W  word written to the output FIFO.
REQ-014 paused  output  1  high while the hysteresis pause is in force.
REQ-015 xfer_count  output  8  total words pushed, wrapping modulo 256.

Function
REQ-016 pop SHALL assert only when state==ACTIVE, paused==0 and at least one in_empty bit is 0.
REQ-017 At most one pop bit SHALL be high in any cycle.
REQ-018 The grant SHALL go to the first non-empty FIFO searching ptr, ptr+1, ... modulo NUM_FIFOS.
REQ-019 On a grant to FIFO i, ptr SHALL become (i+1) mod NUM_FIFOS; with no grant, ptr SHALL hold.
REQ-020 The grant SHALL be combinational on the current inputs; pop is not registered.
REQ-021 A pop to FIFO i in cycle N SHALL produce push=1 in cycle N+1, with data_out taken from in_data slice i.
REQ-022 push SHALL be 0 in any cycle not preceded by a pop, and data_out SHALL then hold its last value.
REQ-023 The effective occupancy SHALL be occ = out_count + push (5-bit sum).
REQ-024 paused SHALL set on the next edge when occ >= umbral_superior.
REQ-025 paused SHALL clear on the next edge when occ <= umbral_inferior and the set condition is false; set has priority over clear.
REQ-026 When umbral_superior==0, paused SHALL remain set permanently; this is the intended behaviour.
REQ-027 When state leaves ACTIVE, no new pop SHALL issue, an in-flight push SHALL still complete, and ptr and paused SHALL hold.
REQ-028 xfer_count SHALL increment by 1 on every push and wrap from 255 to 0.

Reset
REQ-029 On reset, pop SHALL be 0, push 0, data_out 0, paused 0, xfer_count 0 and ptr 0.
REQ-030 The pending push SHALL be cancelled on reset, including a reset asserted mid-transfer.
REQ-031 Reset SHALL take priority over all other inputs.

Structure
REQ-032 The state encodings, NUM_FIFOS and DATA_W defaults SHALL live in a shared package, also used by the controller FSM.
REQ-033 The block SHALL contain one sub-module, rr_priority_sel: a combinational picker with inputs request vector and ptr, and outputs one-hot grant and index.
REQ-034 The pause hysteresis, the ptr register and the push pipeline register SHALL reside in the top module.

Verification
REQ-035 ACTIVE, all FIFOs non-empty, thresholds 7/2, out_count=0 -> pops 0001,0010,0100,1000,0001 in consecutive cycles, each push one cycle later with matching data.
REQ-036 ACTIVE, only FIFO 2 non-empty, ptr=3 -> pop=0100, then ptr=3 and push with FIFO 2 data next cycle.
REQ-037 umbral_superior=4, umbral_inferior=2, out_count rising to 4 -> paused=1 next edge and pop=0; out_count falling to 3 -> still paused; at 2 -> paused=0.
REQ-038 state ACTIVE->IDLE in the same cycle as a pop -> push still occurs next cycle; no further pops while IDLE.
REQ-039 reset asserted the cycle after a pop -> push=0, xfer_count=0, ptr=0.
REQ-040 256 transfers -> xfer_count wraps to 0.
